// File: rtl/ps2_packet_ctrl_if.sv
// Signal bundle between the PS/2 byte receiver, the packet sequencer and the downstream consumer.
// The slave side belongs to ps2_packet_ctrl; the master side drives bytes and accepts packets.
interface ps2_packet_ctrl_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [23:0] pkt_data;
  logic        busy;
  logic        timeout;
  logic        overflow;
  logic [7:0]  drop_cnt;

  modport slave (
    input  in_valid, in_data, pkt_ready,
    output pkt_valid, pkt_data, busy, timeout, overflow, drop_cnt
  );

  modport master (
    output in_valid, in_data, pkt_ready,
    input  pkt_valid, pkt_data, busy, timeout, overflow, drop_cnt
  );
endinterface

// File: rtl/ps2_packet_ctrl.sv
// PS/2 mouse packet sequencer: frames 3-byte packets on byte1 bit 3, abandons stalled frames
// after an idle timeout, and buffers completed packets in a 2-entry FIFO with drop accounting.
module ps2_packet_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  ps2_packet_ctrl_if.slave bus
);

  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    BYTE2 = 2'd1,
    BYTE3 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  byte1_q, byte1_d;
  logic [7:0]  byte2_q, byte2_d;
  logic [15:0] idle_q, idle_d;
  logic        timeout_q, timeout_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, rd_ptr_q;
  logic [23:0] mem_q [2];

  logic push, pop, full, push_ok;

  // Frame sequencer and idle timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned
    // and no latch is inferred; blocking '=' is correct here, '<=' belongs only in always_ff.
    state_d   = state_q;
    byte1_d   = byte1_q;
    byte2_d   = byte2_q;
    idle_d    = idle_q;
    timeout_d = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      SYNC: begin
        idle_d = '0;
        if (bus.in_valid && bus.in_data[3]) begin
          byte1_d = bus.in_data;
          state_d = BYTE2;
        end
      end
      BYTE2, BYTE3: begin
        if (bus.in_valid) begin
          idle_d = '0;
          if (state_q == BYTE2) begin
            byte2_d = bus.in_data;
            state_d = BYTE3;
          end else begin
            push    = 1'b1;
            state_d = SYNC;
          end
        end else if (idle_q == IDLE_LAST) begin
          // A byte arriving on this same cycle takes the branch above and wins over the timeout.
          idle_d    = '0;
          timeout_d = 1'b1;
          state_d   = SYNC;
        end else begin
          idle_d = idle_q + 16'd1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // FIFO control: a pop frees the slot for a same-cycle push when full.
  always_comb begin
    pop        = (count_q != 2'd0) && bus.pkt_ready;
    full       = (count_q == 2'd2);
    push_ok    = push && (!full || pop);
    overflow_d = push && full && !pop;
    count_d    = count_q + {1'b0, push_ok} - {1'b0, pop};
    drop_cnt_d = (overflow_d && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SYNC;
      byte1_q    <= '0;
      byte2_q    <= '0;
      idle_q     <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte1_q    <= byte1_d;
      byte2_q    <= byte2_d;
      idle_q     <= idle_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_q ^ push_ok;
      rd_ptr_q   <= rd_ptr_q ^ pop;
    end
  end

  // NOTE: the packet storage is deliberately not reset; the occupancy count gates every read,
  // so stale contents are never visible and the storage stays plain flops without reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {byte1_q, byte2_q, bus.in_data};
  end

  assign bus.pkt_valid = (count_q != 2'd0);
  assign bus.pkt_data  = bus.pkt_valid ? mem_q[rd_ptr_q] : 24'd0;
  assign bus.busy      = (state_q != SYNC);
  assign bus.timeout   = timeout_q;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ps2_packet_ctrl.sv
// Self-checking bench for ps2_packet_ctrl: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_ps2_packet_ctrl;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  ps2_packet_ctrl_if bus();

  ps2_packet_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bytes of the frame in progress, packets waiting downstream, counters.
  logic [7:0]  m_frame [$];
  logic [23:0] m_fifo  [$];
  int          m_idle;
  int          m_drops;
  bit          m_timeout;
  bit          m_overflow;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_frame.delete();
    m_fifo.delete();
    m_idle     = 0;
    m_drops    = 0;
    m_timeout  = 0;
    m_overflow = 0;
  endtask

  // Advance the model by one clock edge using the inputs that will be sampled at that edge.
  task automatic model_step(input bit v, input logic [7:0] d, input bit rdy);
    bit          done;
    logic [23:0] pkt;
    done       = 0;
    pkt        = '0;
    m_timeout  = 0;
    m_overflow = 0;
    if (v) begin
      m_idle = 0;
      if (m_frame.size() == 2) begin
        pkt  = {m_frame[0], m_frame[1], d};
        done = 1;
        m_frame.delete();
      end else if (m_frame.size() == 1 || d[3]) begin
        m_frame.push_back(d);
      end
    end else if (m_frame.size() > 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_frame.delete();
        m_idle    = 0;
        m_timeout = 1;
      end
    end
    if (rdy && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (done) begin
      if (m_fifo.size() < 2) m_fifo.push_back(pkt);
      else begin
        m_overflow = 1;
        if (m_drops < 255) m_drops++;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pkt_valid"}, 32'(bus.pkt_valid), 32'(m_fifo.size() > 0));
    check({tag, ".pkt_data"},  32'(bus.pkt_data),  (m_fifo.size() > 0) ? 32'(m_fifo[0]) : 32'd0);
    check({tag, ".busy"},      32'(bus.busy),      32'(m_frame.size() > 0));
    check({tag, ".timeout"},   32'(bus.timeout),   32'(m_timeout));
    check({tag, ".overflow"},  32'(bus.overflow),  32'(m_overflow));
    check({tag, ".drop_cnt"},  32'(bus.drop_cnt),  32'(m_drops));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic step(input string tag, input bit v, input logic [7:0] d, input bit rdy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.pkt_ready = rdy;
    model_step(v, d, rdy);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00, rdy);
  endtask

  // Reset pulsed between clock edges; outputs must clear without waiting for an edge.
  task automatic async_reset(input string tag);
    bus.in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    bit         v, r;
    int         pv, pr;

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.pkt_ready = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_outputs("reset_release");

    // Sync hunt: two bytes with bit3=0 are discarded.
    step("hunt", 1'b1, 8'h00, 1'b1);
    step("hunt", 1'b1, 8'h17, 1'b1);
    step("hunt", 1'b1, 8'h08, 1'b1);
    step("hunt", 1'b1, 8'hAA, 1'b1);
    step("hunt", 1'b1, 8'h55, 1'b1);
    check("hunt_pkt", 32'(bus.pkt_data), 32'h08AA55);
    idle("hunt_idle", 2, 1'b1);

    // Back-to-back packets on consecutive cycles.
    step("b2b", 1'b1, 8'h0F, 1'b1);
    step("b2b", 1'b1, 8'h01, 1'b1);
    step("b2b", 1'b1, 8'h02, 1'b1);
    check("b2b_pkt1", 32'(bus.pkt_data), 32'h0F0102);
    step("b2b", 1'b1, 8'h18, 1'b1);
    step("b2b", 1'b1, 8'h03, 1'b1);
    step("b2b", 1'b1, 8'h04, 1'b1);
    check("b2b_pkt2", 32'(bus.pkt_data), 32'h180304);
    idle("b2b_idle", 2, 1'b1);

    // Timeout after TO idle cycles inside a frame.
    step("tmo", 1'b1, 8'h08, 1'b1);
    step("tmo", 1'b1, 8'h11, 1'b1);
    idle("tmo_idle", TO, 1'b1);
    check("tmo_pulse", 32'(bus.timeout), 32'd1);
    check("tmo_busy", 32'(bus.busy), 32'd0);
    step("tmo", 1'b1, 8'h09, 1'b1);
    step("tmo", 1'b1, 8'h22, 1'b1);
    step("tmo", 1'b1, 8'h33, 1'b1);
    check("tmo_pkt", 32'(bus.pkt_data), 32'h092233);
    idle("tmo_idle2", 2, 1'b1);

    // Byte lands exactly on the last idle cycle: accepted, no timeout.
    step("tmo_edge", 1'b1, 8'h08, 1'b1);
    step("tmo_edge", 1'b1, 8'h11, 1'b1);
    idle("tmo_edge_idle", TO - 1, 1'b1);
    step("tmo_edge", 1'b1, 8'h22, 1'b1);
    check("tmo_edge_none", 32'(bus.timeout), 32'd0);
    check("tmo_edge_pkt", 32'(bus.pkt_data), 32'h081122);
    idle("tmo_edge_idle2", 2, 1'b1);

    // Overflow: third packet dropped while downstream stalls.
    async_reset("ovf_reset");
    for (int p = 0; p < 3; p++) begin
      step("ovf", 1'b1, 8'h08, 1'b0);
      step("ovf", 1'b1, 8'(p + 1), 1'b0);
      step("ovf", 1'b1, 8'(p + 16), 1'b0);
    end
    check("ovf_pulse", 32'(bus.overflow), 32'd1);
    check("ovf_drops", 32'(bus.drop_cnt), 32'd1);
    check("ovf_head", 32'(bus.pkt_data), 32'h080110);
    step("ovf_pop", 1'b0, 8'h00, 1'b1);
    check("ovf_second", 32'(bus.pkt_data), 32'h080211);
    idle("ovf_drain", 2, 1'b1);

    // Full FIFO with a pop on the cycle the third packet completes.
    for (int p = 0; p < 3; p++) begin
      step("fullpop", 1'b1, 8'h08, 1'b0);
      step("fullpop", 1'b1, 8'(p + 32), 1'b0);
      step("fullpop", 1'b1, 8'(p + 48), p == 2);
    end
    check("fullpop_noovf", 32'(bus.overflow), 32'd0);
    check("fullpop_head", 32'(bus.pkt_data), 32'h082131);
    idle("fullpop_drain", 3, 1'b1);

    // Reset mid-frame; the following 0x44 does not sync.
    step("rst_mid", 1'b1, 8'h08, 1'b1);
    step("rst_mid", 1'b1, 8'h11, 1'b1);
    async_reset("rst_mid_async");
    step("rst_mid", 1'b1, 8'h44, 1'b1);
    step("rst_mid", 1'b1, 8'h55, 1'b1);
    idle("rst_mid_idle", 3, 1'b1);

    // Sustained stalled stream to saturate the drop counter.
    for (int i = 0; i < 900; i++) step("sat", 1'b1, 8'h08 | 8'($urandom), 1'b0);
    check("sat_drops", 32'(bus.drop_cnt), 32'd255);
    idle("sat_drain", 4, 1'b1);

    // Randomized traffic with varying byte density and downstream readiness.
    for (int phase = 0; phase < 6; phase++) begin
      pv = (phase % 3 == 0) ? 95 : (phase % 3 == 1) ? 70 : 40;
      pr = (phase < 3) ? 90 : 35;
      for (int i = 0; i < 600; i++) begin
        v = ($urandom_range(0, 99) < pv);
        r = ($urandom_range(0, 99) < pr);
        d = 8'($urandom);
        step("rand", v, d, r);
      end
      if (phase == 2) async_reset("rand_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_packet_ctrl.md
# ps2_packet_ctrl

Sequencer for the PS/2 mouse receive path. It takes the raw byte stream from the serial receiver, tracks 3-byte message boundaries using bit 3 of the first byte, and assembles complete packets. Packets are buffered in a 2-entry FIFO and handed downstream over a valid/ready handshake. It also recovers from stalled transfers with an inter-byte timeout and accounts for dropped packets.

## Interface
- TIMEOUT_CYCLES, 1024: idle cycles allowed between bytes of one packet before the frame is abandoned; legal range 2..65535.
- clk  input  1: rising-edge clock for all state.
- reset_n  input  1: asynchronous, active-low reset.
- in_valid  input  1: in_data carries a received byte this cycle; every byte is consumed, there is no backpressure.
- in_data  input  8: received byte.
- pkt_valid  output  1: FIFO head holds a packet.
- pkt_ready  input  1: downstream accepts the head packet when pkt_valid && pkt_ready.
- pkt_data  output  24: head packet as {byte1, byte2, byte3}; byte1 in [23:16].
- busy  output  1: frame in progress (state BYTE2 or BYTE3).
- timeout  output  1: one-cycle pulse; a frame was abandoned.
- overflow  output  1: one-cycle pulse; a completed packet was dropped because the FIFO was full.
- drop_cnt  output  8: count of dropped packets, saturating at 255.

## Operation
- FSM states:
  - SYNC: in_valid with in_data[3]=1 → store byte1, go to BYTE2. in_valid with in_data[3]=0 → discard, stay.
  - BYTE2: in_valid → store byte2, go to BYTE3.
  - BYTE3: in_valid → complete the packet, go to SYNC.
- No DONE dwell: a byte arriving on the cycle after completion is evaluated in SYNC.
- Timeout:
  - 16-bit idle counter. Cleared on every accepted byte and in SYNC.
  - Increments each cycle in BYTE2/BYTE3 without in_valid.
  - If the counter equals TIMEOUT_CYCLES-1 and in_valid=0: go to SYNC, clear the counter, pulse timeout, discard the partial bytes.
  - in_valid on that same cycle wins: the byte is accepted and there is no timeout.
- FIFO: 2 entries, occupancy 0..2.
  - Push on packet completion. Pop on pkt_valid && pkt_ready.
  - Full with a pop in the same cycle: the push is accepted and occupancy stays 2.
  - Full with no pop: the packet is dropped, overflow pulses, drop_cnt increments unless it is already 255.
  - Empty: a pop cannot occur, because pkt_valid=0.
- pkt_data is stable while pkt_valid=1 && pkt_ready=0. pkt_data is 0 when the FIFO is empty.
- Reset mid-frame: partial bytes are lost and FIFO contents are flushed.

## Timing
- Reset values: pkt_valid=0, pkt_data=0, busy=0, timeout=0, overflow=0, drop_cnt=0. FSM=SYNC, FIFO empty, idle counter 0.
- Latency:
  - byte3 sampled at edge N with the FIFO empty → pkt_valid=1 and pkt_data valid after edge N.
  - With a non-empty FIFO, the packet becomes head after the preceding entries pop.
- Throughput: one byte per cycle sustained. One packet per 3 cycles is drained without loss if pkt_ready=1.
- Timing of pulse and status outputs:
  - timeout and overflow are registered and assert for exactly one cycle after the triggering edge.
  - busy reflects the registered FSM state.
  - drop_cnt updates after the same edge as overflow.
- reset_n assertion clears all state immediately, regardless of clk. The first edge after deassertion behaves as SYNC.

## Test plan
- Sync hunt:
  - Stimulus: bytes 0x00, 0x17 (bit3=0), then 0x08, 0xAA, 0x55 on consecutive cycles, pkt_ready=1.
  - Response: the first two are discarded; pkt_valid one cycle with pkt_data=0x08AA55; busy high for 2 cycles.
- Back-to-back stream:
  - Stimulus: 0x0F,0x01,0x02,0x18,0x03,0x04 on consecutive cycles.
  - Response: packets 0x0F0102 then 0x180304; no timeout or overflow.
- Timeout, TIMEOUT_CYCLES=4:
  - Stimulus: 0x08, 0x11, then 4 idle cycles, then 0x09,0x22,0x33.
  - Response: timeout pulses once, busy drops, next packet=0x092233. Repeat with the byte arriving exactly on idle cycle 4 → no timeout.
- Overflow:
  - Stimulus: pkt_ready=0, send 3 valid packets.
  - Response: FIFO holds packets 1 and 2; packet 3 gives an overflow pulse and drop_cnt=1; then pkt_ready=1 pops 1 then 2 in order.
- Full with simultaneous pop:
  - Stimulus: FIFO full, pkt_ready=1 on the cycle packet 3 completes.
  - Response: no overflow; the output order is 1, 2, 3.
- Async reset mid-frame:
  - Stimulus: after 0x08,0x11, pulse reset_n low between edges.
  - Response: all outputs go to 0 immediately; a following 0x44,0x55 produces no packet, since 0x44 has bit3=0.
